dtm_dmi_ctrl: RTL and testbench
===============================

DTM_DMI_CTRL -- requirements
Module: dtm_dmi_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 7, DMI address width.
REQ-002 SHALL have parameter DMI_W, default ABITS+34, DMI scan register length {addr, data[31:0], op[1:0]}.
REQ-003 SHALL have ports, in this order: TCK_i  in  1  sole clock, all state on rising edge.
REQ-004 TRST_ni  in  1  reset, asynchronous, active-low.
REQ-005 TDI_i  in  1  serial data in; capture_i, shift_i, update_i  in  1 each  TAP DR-state strobes.
REQ-006 DMI_select_i  in  1  IR selects DMI access; DMI_clear_i  in  1  TAP test-logic-reset, synchronous clear.
REQ-007 dmireset_i  in  1  clear sticky error; dmihardreset_i  in  1  abort transaction.
REQ-008 DMI_TDO_o  out  1  serial data out to TAP mux.
REQ-009 dmi_req_valid_o out 1; dmi_req_ready_i in 1; dmi_req_addr_o out ABITS; dmi_req_data_o out 32; dmi_req_op_o out 2.
REQ-010 dmi_resp_valid_i in 1; dmi_resp_ready_o out 1; dmi_resp_data_i in 32; dmi_resp_op_i in 2 (0 ok, 2 failed).
REQ-011 dmistat_o  out  2  sticky status for DTM CSR (0 none, 2 failed, 3 busy).

Function
REQ-012 SHALL implement FSM IDLE, REQ, RESP.
REQ-013 Shift register SHALL load on capture_i&DMI_select_i: [1:0]=captured op, [33:2]=last response data, [DMI_W-1:34]=last request address.
REQ-014 Captured op SHALL be 3 if state!=IDLE, else current sticky value.
REQ-015 On shift_i&DMI_select_i SHALL shift right, TDI_i into MSB; DMI_TDO_o SHALL equal shift[0] combinationally.
REQ-016 On update_i&DMI_select_i in IDLE with sticky==0 and op 1 (read) or 2 (write): latch addr/data/op, enter REQ; dmi_req_valid_o high the following cycle.
REQ-017 Update with op 0 or 3 SHALL issue nothing.
REQ-018 In REQ, dmi_req_valid_o SHALL stay high and addr/data/op stable until dmi_req_ready_i sampled high, then enter RESP.
REQ-019 In RESP, dmi_resp_ready_o SHALL be 1; on dmi_resp_valid_i latch resp data, go IDLE; if resp op==2 set sticky=2.
REQ-020 Update in REQ or RESP SHALL be ignored and set sticky=3; capture in REQ or RESP SHALL set sticky=3.
REQ-021 Update in IDLE with sticky!=0 SHALL be ignored.
REQ-022 Sticky SHALL hold the first error until dmireset_i; 3 SHALL not be overwritten by 2.
REQ-023 dmireset_i SHALL clear sticky only; it SHALL take priority over a same-cycle sticky set; FSM unaffected.
REQ-024 dmihardreset_i or DMI_clear_i SHALL force IDLE, drop valid/ready next cycle, clear sticky, discard pending response; priority over all other inputs.
REQ-025 Strobes with DMI_select_i low SHALL have no effect.

Reset
REQ-026 On TRST_ni low: state IDLE, shift reg 0, latched addr/data 0, sticky 0, dmi_req_valid_o 0, dmi_resp_ready_o 0, dmi_req_* 0, DMI_TDO_o 0.
REQ-027 Reset assertion mid-transaction SHALL abandon it; no handshake resumes after release.

Structure
REQ-028 Package dtm_pkg SHALL hold ABITS default, dmi_op enum (NOP, READ, WRITE, RSVD), dmi status encodings, DMI request/response structs, FSM state enum.
REQ-029 Shift register SHALL be sub-module dtm_dmi_shift_reg (capture/shift, parameter DMI_W); FSM and sticky logic stay in dtm_dmi_ctrl.

Verification
REQ-030 Write addr 0x10 data 0xDEADBEEF op 2, ready high -> valid one cycle, addr 0x10, data 0xDEADBEEF, op 2; RESP; resp ok -> IDLE, capture op 0.
REQ-031 Read addr 0x11, resp data 0x12345678 op 0 -> next capture shifts out op 0, data 0x12345678, addr 0x11, LSB first.
REQ-032 dmi_req_ready_i low 5 cycles -> valid and payload held stable 5 cycles; capture during wait -> op 3, dmistat_o 3; later update ignored.
REQ-033 Resp op 2 -> dmistat_o 2; next write ignored (valid stays 0); dmireset_i -> dmistat_o 0; next write issued.
REQ-034 dmihardreset_i in RESP -> IDLE next cycle, dmi_resp_ready_o 0, dmistat_o 0; late resp_valid ignored.
REQ-035 TRST_ni low during REQ -> all outputs 0 immediately; after release no request until new update.

Source files
------------

// File: rtl/dtm_dmi_ctrl_pkg.sv
// Shared types for the JTAG DTM DMI access controller.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package dtm_pkg;

   localparam int ABITS_DEF  = 7;
   localparam int DMI_DATA_W = 32;

   typedef enum logic [1:0] {
      DMI_NOP   = 2'd0,
      DMI_READ  = 2'd1,
      DMI_WRITE = 2'd2,
      DMI_RSVD  = 2'd3
   } dmi_op_e;

   // Sticky status reported through dtmcs.dmistat
   localparam logic [1:0] DMI_STAT_NONE   = 2'd0;
   localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
   localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

   // Response op codes returned by the debug module
   localparam logic [1:0] DMI_RESP_OK     = 2'd0;
   localparam logic [1:0] DMI_RESP_FAILED = 2'd2;

   // Request payload; the address is kept separately because its width is a parameter
   typedef struct packed {
      logic [DMI_DATA_W-1:0] data;
      dmi_op_e               op;
   } dmi_req_t;

   typedef struct packed {
      logic [DMI_DATA_W-1:0] data;
      logic [1:0]            op;
   } dmi_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } dtm_state_e;

   // Only reads and writes start a bus transaction
   function automatic logic is_access(input logic [1:0] op);
      return (op == DMI_READ) || (op == DMI_WRITE);
   endfunction

endpackage

// File: rtl/dtm_dmi_ctrl_if.sv
// DMI request/response bus between the DTM (master) and the debug module (slave).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request and the response channel.
interface dtm_dmi_ctrl_if #(
   parameter int ABITS = dtm_pkg::ABITS_DEF
);
   logic             req_valid;
   logic             req_ready;
   logic [ABITS-1:0] req_addr;
   logic [31:0]      req_data;
   logic [1:0]       req_op;
   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_data;
   logic [1:0]       resp_op;

   modport master (
      output req_valid, req_addr, req_data, req_op, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_op
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_op, resp_ready,
      output req_ready, resp_valid, resp_data, resp_op
   );
endinterface

// File: rtl/dtm_dmi_shift_reg.sv
// DMI scan data register: parallel capture, serial right shift with TDI entering the MSB.
// Latency: capture/shift take effect on the next TCK rising edge.
// Backpressure: none; strobes are acted on every cycle they are high.
module dtm_dmi_shift_reg #(
   parameter int DMI_W = 41
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             capture_i,
   input  logic             shift_i,
   input  logic             tdi_i,
   input  logic [DMI_W-1:0] cap_dat_i,
   output logic [DMI_W-1:0] sr_o
);

   logic [DMI_W-1:0] sr_q, sr_d;

   // Capture wins over shift if the TAP ever asserts both
   always_comb begin
      sr_d = sr_q;
      if (capture_i) begin
         sr_d = cap_dat_i;
      end else if (shift_i) begin
         sr_d = {tdi_i, sr_q[DMI_W-1:1]};
      end
   end

   // Scan register state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign sr_o = sr_q;

endmodule

// File: rtl/dtm_dmi_ctrl.sv
// DTM DMI access controller: turns DR updates into DMI requests and tracks sticky status.
// Latency: request valid one TCK after update; response latched on the cycle it is accepted.
// Backpressure: holds the request until ready; accesses arriving while busy set sticky busy.
module dtm_dmi_ctrl
   import dtm_pkg::*;
#(
   parameter int ABITS = ABITS_DEF,
   parameter int DMI_W = ABITS + 34
) (
   input  logic             TCK_i,
   input  logic             TRST_ni,
   input  logic             TDI_i,
   input  logic             capture_i,
   input  logic             shift_i,
   input  logic             update_i,
   input  logic             DMI_select_i,
   input  logic             DMI_clear_i,
   input  logic             dmireset_i,
   input  logic             dmihardreset_i,
   output logic             DMI_TDO_o,
   output logic             dmi_req_valid_o,
   input  logic             dmi_req_ready_i,
   output logic [ABITS-1:0] dmi_req_addr_o,
   output logic [31:0]      dmi_req_data_o,
   output logic [1:0]       dmi_req_op_o,
   input  logic             dmi_resp_valid_i,
   output logic             dmi_resp_ready_o,
   input  logic [31:0]      dmi_resp_data_i,
   input  logic [1:0]       dmi_resp_op_i,
   output logic [1:0]       dmistat_o
);

   dtm_state_e       state_q, state_d;
   logic [ABITS-1:0] addr_q, addr_d;
   dmi_req_t         req_q, req_d;
   logic [31:0]      resp_data_q, resp_data_d;
   logic [1:0]       sticky_q, sticky_d;
   logic [DMI_W-1:0] sr;
   logic [DMI_W-1:0] cap_dat;
   logic             cap_en, shift_en, upd_en, abort, busy_hit;
   dmi_resp_t        resp;

   assign cap_en   = capture_i & DMI_select_i;
   assign shift_en = shift_i & DMI_select_i;
   assign upd_en   = update_i & DMI_select_i;
   assign abort    = dmihardreset_i | DMI_clear_i;
   assign busy_hit = (cap_en | upd_en) & (state_q != ST_IDLE);
   assign resp     = {dmi_resp_data_i, dmi_resp_op_i};

   // Debugger sees "busy" while a transaction is outstanding, else the sticky status
   assign cap_dat = {addr_q, resp_data_q,
                     (state_q != ST_IDLE) ? DMI_STAT_BUSY : sticky_q};

   dtm_dmi_shift_reg #(
      .DMI_W(DMI_W)
   ) u_shift_reg (
      .clk       (TCK_i),
      .rst_n     (TRST_ni),
      .capture_i (cap_en),
      .shift_i   (shift_en),
      .tdi_i     (TDI_i),
      .cap_dat_i (cap_dat),
      .sr_o      (sr)
   );

   // Next state, request latch, response latch and sticky status
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      req_d       = req_q;
      resp_data_d = resp_data_q;
      sticky_d    = sticky_q;

      unique case (state_q)
         ST_IDLE: begin
            if (upd_en && (sticky_q == DMI_STAT_NONE) && is_access(sr[1:0])) begin
               addr_d     = sr[DMI_W-1:34];
               req_d.data = sr[33:2];
               req_d.op   = dmi_op_e'(sr[1:0]);
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (dmi_req_ready_i) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (dmi_resp_valid_i) begin
               resp_data_d = resp.data;
               state_d     = ST_IDLE;
               if ((resp.op == DMI_RESP_FAILED) && (sticky_q == DMI_STAT_NONE)) begin
                  sticky_d = DMI_STAT_FAILED;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Busy outranks a same-cycle failure, but never replaces an earlier error
      if (busy_hit && (sticky_q == DMI_STAT_NONE)) begin
         sticky_d = DMI_STAT_BUSY;
      end

      if (dmireset_i) begin
         sticky_d = DMI_STAT_NONE;
      end

      // Abort drops everything in flight, including any response arriving this cycle
      if (abort) begin
         state_d     = ST_IDLE;
         addr_d      = addr_q;
         req_d       = req_q;
         resp_data_d = resp_data_q;
         sticky_d    = DMI_STAT_NONE;
      end
   end

   // Controller state registers
   always_ff @(posedge TCK_i or negedge TRST_ni) begin
      if (!TRST_ni) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         req_q       <= '0;
         resp_data_q <= '0;
         sticky_q    <= DMI_STAT_NONE;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         req_q       <= req_d;
         resp_data_q <= resp_data_d;
         sticky_q    <= sticky_d;
      end
   end

   assign DMI_TDO_o        = sr[0];
   assign dmi_req_valid_o  = (state_q == ST_REQ);
   assign dmi_resp_ready_o = (state_q == ST_RESP);
   assign dmi_req_addr_o   = addr_q;
   assign dmi_req_data_o   = req_q.data;
   assign dmi_req_op_o     = req_q.op;
   assign dmistat_o        = sticky_q;

endmodule

// File: tb/tb_dtm_dmi_ctrl.sv
// Bench for dtm_dmi_ctrl: drives DR scans over the TAP strobes and plays the debug module.
// Latency: n/a.
// Backpressure: bench controls req_ready and resp_valid directly.
module tb_dtm_dmi_ctrl;
   import dtm_pkg::*;

   localparam int ABITS = 7;
   localparam int DMI_W = ABITS + 34;

   typedef struct packed {
      logic [ABITS-1:0] addr;
      logic [31:0]      data;
      logic [1:0]       op;
   } vec_t;

   logic       tck = 1'b0;
   logic       trst_n = 1'b0;
   logic       tdi = 1'b0;
   logic       capture = 1'b0;
   logic       shift = 1'b0;
   logic       update = 1'b0;
   logic       sel = 1'b0;
   logic       clr = 1'b0;
   logic       dmireset = 1'b0;
   logic       hardreset = 1'b0;
   logic       tdo;
   logic [1:0] dmistat;

   dtm_dmi_ctrl_if #(.ABITS(ABITS)) dmi ();

   always #5 tck = ~tck;

   dtm_dmi_ctrl #(.ABITS(ABITS), .DMI_W(DMI_W)) dut (
      .TCK_i            (tck),
      .TRST_ni          (trst_n),
      .TDI_i            (tdi),
      .capture_i        (capture),
      .shift_i          (shift),
      .update_i         (update),
      .DMI_select_i     (sel),
      .DMI_clear_i      (clr),
      .dmireset_i       (dmireset),
      .dmihardreset_i   (hardreset),
      .DMI_TDO_o        (tdo),
      .dmi_req_valid_o  (dmi.req_valid),
      .dmi_req_ready_i  (dmi.req_ready),
      .dmi_req_addr_o   (dmi.req_addr),
      .dmi_req_data_o   (dmi.req_data),
      .dmi_req_op_o     (dmi.req_op),
      .dmi_resp_valid_i (dmi.resp_valid),
      .dmi_resp_ready_o (dmi.resp_ready),
      .dmi_resp_data_i  (dmi.resp_data),
      .dmi_resp_op_i    (dmi.resp_op),
      .dmistat_o        (dmistat)
   );

   int n_chk  = 0;
   int n_pass = 0;

   vec_t exp_req[$];
   vec_t exp_cap[$];

   // Reference model of what the next capture should show
   logic [ABITS-1:0] m_addr = '0;
   logic [31:0]      m_resp = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic vec_t mk(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [1:0] o);
      vec_t v;
      v.addr = a;
      v.data = d;
      v.op   = o;
      return v;
   endfunction

   function automatic logic [45:0] outs();
      return {dmi.req_valid, dmi.resp_ready, dmi.req_addr, dmi.req_data, dmi.req_op, tdo, dmistat};
   endfunction

   function automatic vec_t req_now();
      return mk(dmi.req_addr, dmi.req_data, dmi.req_op);
   endfunction

   // Request scoreboard: every accepted request must match the oldest expected one
   always @(negedge tck) begin : req_mon
      vec_t e;
      if (trst_n && dmi.req_valid && dmi.req_ready) begin
         if (exp_req.size() == 0) begin
            check("req_unexpected", exp_req.size(), 1);
         end else begin
            e = exp_req.pop_front();
            check("req_handshake", req_now(), e);
         end
      end
   end

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic push_cap(input logic [1:0] op);
      exp_cap.push_back(mk(m_addr, m_resp, op));
   endtask

   // Capture, then shift DMI_W bits LSB first while collecting TDO
   task automatic scan_check(input string tag, input vec_t din);
      logic [DMI_W-1:0] dv;
      logic [DMI_W-1:0] dout;
      vec_t e;
      dv = din;
      sel = 1'b1;
      capture = 1'b1;
      tick();
      capture = 1'b0;
      for (int i = 0; i < DMI_W; i++) begin
         dout[i] = tdo;
         tdi = dv[i];
         shift = 1'b1;
         tick();
      end
      shift = 1'b0;
      tdi = 1'b0;
      if (exp_cap.size() == 0) begin
         check({tag, "_noexp"}, exp_cap.size(), 1);
      end else begin
         e = exp_cap.pop_front();
         check(tag, dout, e);
      end
   endtask

   task automatic upd();
      sel = 1'b1;
      update = 1'b1;
      tick();
      update = 1'b0;
   endtask

   task automatic access(input string tag, input vec_t din);
      scan_check(tag, din);
      upd();
   endtask

   task automatic respond(input string tag, input logic [31:0] d, input logic [1:0] o);
      int n;
      n = 0;
      while (!dmi.resp_ready && n < 10) begin
         tick();
         n++;
      end
      check({tag, "_resp_rdy"}, dmi.resp_ready, 1);
      dmi.resp_valid = 1'b1;
      dmi.resp_data  = d;
      dmi.resp_op    = o;
      tick();
      dmi.resp_valid = 1'b0;
      m_resp = d;
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      vec_t v;
      dmi.req_ready  = 1'b1;
      dmi.resp_valid = 1'b0;
      dmi.resp_data  = '0;
      dmi.resp_op    = '0;

      #12;
      check("rst_outs", outs(), 0);
      tick();
      trst_n = 1'b1;
      tick();

      // Write 0x10 with ready already high
      push_cap(DMI_STAT_NONE);
      v = mk(7'h10, 32'hDEADBEEF, DMI_WRITE);
      exp_req.push_back(v);
      access("s1_cap_rst", v);
      m_addr = 7'h10;
      check("s1_valid", dmi.req_valid, 1);
      check("s1_payload", req_now(), v);
      tick();
      check("s1_valid_1cyc", dmi.req_valid, 0);
      check("s1_in_resp", dmi.resp_ready, 1);
      respond("s1", 32'hCAFE0001, DMI_RESP_OK);
      check("s1_idle", dmi.resp_ready, 0);
      push_cap(DMI_STAT_NONE);
      scan_check("s1_cap_ok", mk(0, 0, DMI_NOP));

      // Read 0x11 and scan its response out
      push_cap(DMI_STAT_NONE);
      v = mk(7'h11, 32'h0, DMI_READ);
      exp_req.push_back(v);
      access("s2_cap_pre", v);
      m_addr = 7'h11;
      check("s2_valid", dmi.req_valid, 1);
      tick();
      respond("s2", 32'h12345678, DMI_RESP_OK);
      push_cap(DMI_STAT_NONE);
      scan_check("s2_cap_rdata", mk(0, 0, DMI_NOP));

      // Ready held low: request must stay put, capture reports busy
      dmi.req_ready = 1'b0;
      push_cap(DMI_STAT_NONE);
      v = mk(7'h12, 32'hA5A5A5A5, DMI_WRITE);
      access("s3_cap_pre", v);
      m_addr = 7'h12;
      for (int i = 0; i < 5; i++) begin
         check("s3_hold", {dmi.req_valid, req_now()}, {1'b1, v});
         tick();
      end
      push_cap(DMI_STAT_BUSY);
      scan_check("s3_cap_busy", mk(7'h13, 32'h1, DMI_WRITE));
      check("s3_stat_busy", dmistat, DMI_STAT_BUSY);
      upd();
      check("s3_upd_ignored", {dmi.req_valid, req_now()}, {1'b1, v});
      exp_req.push_back(v);
      dmi.req_ready = 1'b1;
      tick();
      check("s3_accepted", dmi.req_valid, 0);
      respond("s3", 32'h0BADF00D, DMI_RESP_OK);
      check("s3_stat_kept", dmistat, DMI_STAT_BUSY);
      push_cap(DMI_STAT_BUSY);
      access("s3_cap_sticky", mk(7'h14, 32'h55, DMI_WRITE));
      for (int i = 0; i < 3; i++) begin
         check("s3_no_req", dmi.req_valid, 0);
         tick();
      end
      dmireset = 1'b1;
      tick();
      dmireset = 1'b0;
      check("s3_dmireset", dmistat, DMI_STAT_NONE);

      // Failed response sets sticky 2 and blocks the next access
      push_cap(DMI_STAT_NONE);
      v = mk(7'h15, 32'h77, DMI_WRITE);
      exp_req.push_back(v);
      access("s4_cap_pre", v);
      m_addr = 7'h15;
      tick();
      respond("s4", 32'hFFFF0000, DMI_RESP_FAILED);
      check("s4_stat_failed", dmistat, DMI_STAT_FAILED);
      push_cap(DMI_STAT_FAILED);
      access("s4_cap_failed", mk(7'h16, 32'h88, DMI_WRITE));
      for (int i = 0; i < 3; i++) begin
         check("s4_no_req", dmi.req_valid, 0);
         tick();
      end
      dmireset = 1'b1;
      tick();
      dmireset = 1'b0;
      check("s4_dmireset", dmistat, DMI_STAT_NONE);
      push_cap(DMI_STAT_NONE);
      v = mk(7'h17, 32'h99, DMI_WRITE);
      exp_req.push_back(v);
      access("s4_cap_post", v);
      m_addr = 7'h17;
      check("s4_reissued", dmi.req_valid, 1);
      tick();
      respond("s4b", 32'h00000001, DMI_RESP_OK);
      check("s4_stat_ok", dmistat, DMI_STAT_NONE);

      // Update with select low must not issue the write still sitting in the scan register
      sel = 1'b0;
      update = 1'b1;
      tick();
      update = 1'b0;
      check("sel_low_upd", dmi.req_valid, 0);
      tick();
      check("sel_low_upd2", dmi.req_valid, 0);

      // Hard reset while waiting for the response
      push_cap(DMI_STAT_NONE);
      v = mk(7'h18, 32'hAB, DMI_READ);
      exp_req.push_back(v);
      access("s5_cap_pre", v);
      m_addr = 7'h18;
      tick();
      check("s5_in_resp", dmi.resp_ready, 1);
      push_cap(DMI_STAT_BUSY);
      scan_check("s5_cap_busy", mk(0, 0, DMI_NOP));
      check("s5_stat_busy", dmistat, DMI_STAT_BUSY);
      hardreset = 1'b1;
      tick();
      hardreset = 1'b0;
      check("s5_hard_outs", {dmi.resp_ready, dmi.req_valid, dmistat}, 0);
      dmi.resp_valid = 1'b1;
      dmi.resp_data  = 32'hBAD0BAD0;
      tick();
      tick();
      dmi.resp_valid = 1'b0;
      check("s5_late_resp", dmi.resp_ready, 0);
      push_cap(DMI_STAT_NONE);
      scan_check("s5_cap_after", mk(0, 0, DMI_NOP));

      // Test-logic-reset while a request is pending
      dmi.req_ready = 1'b0;
      push_cap(DMI_STAT_NONE);
      access("clr_cap_pre", mk(7'h19, 32'h3C, DMI_WRITE));
      m_addr = 7'h19;
      check("clr_valid", dmi.req_valid, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_dropped", dmi.req_valid, 0);
      dmi.req_ready = 1'b1;
      tick();
      check("clr_stays_idle", dmi.req_valid, 0);

      // TRST during REQ clears everything at once
      dmi.req_ready = 1'b0;
      push_cap(DMI_STAT_NONE);
      access("s6_cap_pre", mk(7'h1A, 32'hC3, DMI_WRITE));
      check("s6_valid", dmi.req_valid, 1);
      trst_n = 1'b0;
      #1;
      check("s6_trst_outs", outs(), 0);
      tick();
      trst_n = 1'b1;
      dmi.req_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("s6_no_resume", dmi.req_valid, 0);
         tick();
      end
      m_addr = '0;
      m_resp = '0;
      push_cap(DMI_STAT_NONE);
      v = mk(7'h1B, 32'h5, DMI_READ);
      exp_req.push_back(v);
      access("s6_cap_post", v);
      m_addr = 7'h1B;
      check("s6_new_req", dmi.req_valid, 1);
      tick();
      respond("s6", 32'h42, DMI_RESP_OK);

      tick();
      check("req_q_empty", exp_req.size(), 0);
      check("cap_q_empty", exp_cap.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
